// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback formatting.
// Holds the retiring instruction and drives the register-file write port
// (rd/wd/we). Also exposes the misaligned-load level and a retired count.
module wb_stage #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                m_valid,
    input  logic [31:0]         m_pc,
    input  logic [31:0]         m_alu_res,
    input  logic [31:0]         m_dm_rdata,
    input  logic [1:0]          m_wsel,
    input  logic [2:0]          m_ld_type,
    input  logic [4:0]          m_rd,
    input  logic                m_we,
    output logic [4:0]          gpr_rd,
    output logic [31:0]         gpr_wd,
    output logic                gpr_we,
    output logic                w_valid,
    output logic [31:0]         w_pc,
    output logic                ld_misalign,
    output logic [RETIRE_W-1:0] retired
);

    localparam logic [1:0] WSEL_ALU  = 2'd0;
    localparam logic [1:0] WSEL_LOAD = 2'd1;
    localparam logic [1:0] WSEL_LINK = 2'd2;

    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;

    logic                valid;
    logic [31:0]         pc;
    logic [31:0]         alu_res;
    logic [31:0]         dm_rdata;
    logic [1:0]          wsel;
    logic [2:0]          ld_type;
    logic [4:0]          rd;
    logic                we;
    logic [RETIRE_W-1:0] retired_q;

    logic [1:0]  addr_lo;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] wd_raw;
    logic        half_ld;
    logic        word_ld;
    logic        misalign;
    logic        we_eff;

    // Stage register: rst beats flush beats stall beats capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= 1'b0;
            pc        <= '0;
            alu_res   <= '0;
            dm_rdata  <= '0;
            wsel      <= '0;
            ld_type   <= '0;
            rd        <= '0;
            we        <= 1'b0;
            retired_q <= '0;
        end else if (flush) begin
            valid     <= 1'b0;
            pc        <= '0;
            alu_res   <= '0;
            dm_rdata  <= '0;
            wsel      <= '0;
            ld_type   <= '0;
            rd        <= '0;
            we        <= 1'b0;
        end else if (!stall) begin
            valid     <= m_valid;
            pc        <= m_pc;
            alu_res   <= m_alu_res;
            dm_rdata  <= m_dm_rdata;
            wsel      <= m_wsel;
            ld_type   <= m_ld_type;
            rd        <= m_rd;
            we        <= m_we;
            if (m_valid) retired_q <= retired_q + RETIRE_W'(1);
        end
    end

    // Pick the addressed byte / half-word from the raw memory word.
    always_comb begin
        addr_lo = alu_res[1:0];
        case (addr_lo)
            2'd0:    ld_byte = dm_rdata[7:0];
            2'd1:    ld_byte = dm_rdata[15:8];
            2'd2:    ld_byte = dm_rdata[23:16];
            default: ld_byte = dm_rdata[31:24];
        endcase
        ld_half = addr_lo[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    end

    // Extend the selected lane; unknown load types behave as LW.
    always_comb begin
        case (ld_type)
            LD_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            LD_LBU:  ld_data = {24'd0, ld_byte};
            LD_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            LD_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = dm_rdata;
        endcase
    end

    // Misalignment only matters for loads; byte loads never fault.
    always_comb begin
        half_ld  = (ld_type == LD_LH) || (ld_type == LD_LHU);
        word_ld  = (ld_type == 3'd0) || (ld_type > LD_LHU);
        misalign = valid && (wsel == WSEL_LOAD) &&
                   ((half_ld && addr_lo[0]) || (word_ld && (addr_lo != 2'd0)));
    end

    // Write-data mux and enable; data is zeroed when no write happens.
    always_comb begin
        case (wsel)
            WSEL_ALU:  wd_raw = alu_res;
            WSEL_LOAD: wd_raw = ld_data;
            WSEL_LINK: wd_raw = pc + 32'd8;
            default:   wd_raw = 32'd0;
        endcase
        we_eff      = valid && we && (rd != 5'd0) && !misalign;
        gpr_we      = we_eff;
        gpr_wd      = we_eff ? wd_raw : 32'd0;
        gpr_rd      = rd;
        w_valid     = valid;
        w_pc        = pc;
        ld_misalign = misalign;
        retired     = retired_q;
    end

endmodule
